// File: rtl/oled_frame_streamer.sv
// oled_frame_streamer: scans a full frame of (x,y) coordinates through the
// combinational renderer and serialises each RGB565 word MSB-first on an
// SPI-style link (sclk idle low, data changes on falling edges, cs_n per frame).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; x=y=0 presented, cs_n high
// S_LOAD  | capture renderer output for the stable (x,y) into shreg
// S_SHIFT | clock 16 bits out, CLK_DIV cycles per sclk half-period
// S_NEXT  | advance raster position or finish the frame
// S_DONE  | one-cycle frame_done pulse; restart if continuous
module oled_frame_streamer #(
    parameter int WIDTH   = 96,
    parameter int HEIGHT  = 64,
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        continuous,
    input  logic [15:0] pixel_data,
    output logic [6:0]  x,
    output logic [5:0]  y,
    output logic [12:0] pixel_index,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic        busy,
    output logic        frame_done
);

    // Divider needs at least one bit even when CLK_DIV is 1.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [6:0] X_LAST = 7'(WIDTH - 1);
    localparam logic [5:0] Y_LAST = 6'(HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [3:0]         bit_cnt;
    logic [15:0]        shreg;

    // The shift register MSB is the serial data; it is cleared outside SHIFT
    // so mosi rests low between pixels and frames.
    assign mosi = shreg[15];

    // Frame sequencer: state, raster position, serialiser and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            x           <= '0;
            y           <= '0;
            pixel_index <= '0;
            sclk        <= 1'b0;
            cs_n        <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        cs_n  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end

                S_LOAD: begin
                    shreg   <= pixel_data;
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    sclk    <= 1'b0;
                    state   <= S_SHIFT;
                end

                S_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        // Falling edge: move to the next bit or finish the word.
                        if (sclk) begin
                            if (bit_cnt == 4'd15) begin
                                shreg <= '0;
                                state <= S_NEXT;
                            end else begin
                                shreg   <= {shreg[14:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                S_NEXT: begin
                    if (x == X_LAST && y == Y_LAST) begin
                        x           <= '0;
                        y           <= '0;
                        pixel_index <= '0;
                        cs_n        <= 1'b1;
                        frame_done  <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        // Raster order means the linear index is just a running count.
                        pixel_index <= pixel_index + 13'd1;
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= y + 6'd1;
                        end else begin
                            x <= x + 7'd1;
                        end
                        state <= S_LOAD;
                    end
                end

                S_DONE: begin
                    frame_done <= 1'b0;
                    if (continuous) begin
                        cs_n  <= 1'b0;
                        state <= S_LOAD;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    cs_n  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
